// File: rtl/exp_add_pkg.sv
// Shared types for the FP-unit exponent add/sub arbiter.
// Struct fields are sized by the package widths EXP_W/TAG_W.
package exp_add_pkg;

   localparam int EXP_W = 8;
   localparam int TAG_W = 4;

   typedef logic req_id_t;

   typedef struct packed {
      logic [EXP_W-1:0] a;
      logic [EXP_W-1:0] b;
      logic             sub;
      logic [TAG_W-1:0] tag;
   } exp_req_t;

   typedef struct packed {
      logic [EXP_W-1:0] sum;
      logic             cout;
      req_id_t          id;
      logic [TAG_W-1:0] tag;
   } exp_rsp_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/exp_add_core.sv
// Combinational Kogge-Stone add/subtract: sum = a + (sub ? ~b : b) + sub.
// The carry-in (sub) is folded in after the prefix tree.
module exp_add_core
   import exp_add_pkg::*;
#(
   parameter int W = EXP_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int LVL = $clog2(W);

   logic [W-1:0] w_bx;
   logic [W-1:0] w_g [LVL+1];
   logic [W-1:0] w_p [LVL+1];
   logic [W:0]   w_c;

   assign w_bx   = sub ? ~b : b;
   assign w_g[0] = a & w_bx;
   assign w_p[0] = a ^ w_bx;

   for (genvar l = 0; l < LVL; l++) begin : g_lvl
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (i >= (1 << l)) begin : g_op
            assign w_g[l+1][i] = w_g[l][i] |
                                 (w_p[l][i] & w_g[l][i-(1<<l)]);
            assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
         end else begin : g_pass
            assign w_g[l+1][i] = w_g[l][i];
            assign w_p[l+1][i] = w_p[l][i];
         end
      end
   end

   // w_p[LVL][i] is the group propagate of bits 0..i
   assign w_c  = {w_g[LVL] | (w_p[LVL] & {W{sub}}), sub};
   assign sum  = w_p[0] ^ w_c[W-1:0];
   assign cout = w_c[W];

endmodule

// File: rtl/exp_add_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// Optional EXP_ADD_ARB_PERF_EN adds saturating grant/stall counters.
module exp_add_arbiter
   import exp_add_pkg::*;
#(
   parameter int W     = EXP_W,
   parameter int TAG_W = exp_add_pkg::TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [W-1:0]     req0_a,
   input  logic [W-1:0]     req0_b,
   input  logic             req0_sub,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [W-1:0]     req1_a,
   input  logic [W-1:0]     req1_b,
   input  logic             req1_sub,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag
`ifdef EXP_ADD_ARB_PERF_EN
  ,output logic [15:0]      perf_grant0,
   output logic [15:0]      perf_grant1,
   output logic [15:0]      perf_stall
`endif
);

   out_state_e r_state;
   out_state_e w_state_nxt;
   exp_rsp_t   r_rsp;
   req_id_t    r_rr_ptr;

   exp_req_t   w_req0;
   exp_req_t   w_req1;
   exp_req_t   w_sel;
   logic [1:0] w_grant;
   logic [1:0] w_hs_vec;
   logic       w_hs;
   logic       w_can_accept;
   req_id_t    w_gnt_id;
   logic [W-1:0] w_sum;
   logic       w_cout;

   assign w_req0 = '{a: req0_a, b: req0_b, sub: req0_sub, tag: req0_tag};
   assign w_req1 = '{a: req1_a, b: req1_b, sub: req1_sub, tag: req1_tag};

   always_comb begin
      w_grant = 2'b00;
      unique case (req_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
         default: w_grant = 2'b00;
      endcase
   end

   assign rsp_valid    = (r_state == ST_FULL);
   assign w_can_accept = !rsp_valid || rsp_ready;
   assign req_ready    = {2{w_can_accept}} & w_grant;
   assign w_hs_vec     = req_valid & req_ready;
   assign w_hs         = |w_hs_vec;
   assign w_gnt_id     = w_grant[1];
   assign w_sel        = w_gnt_id ? w_req1 : w_req0;

   exp_add_core #(.W(W)) u_core (
      .a    (w_sel.a),
      .b    (w_sel.b),
      .sub  (w_sel.sub),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_hs) w_state_nxt = ST_FULL;
         ST_FULL:  if (rsp_ready && !w_hs) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // Pointer moves only on a handshake so a stalled grant never hops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp    <= '0;
         r_rr_ptr <= 1'b0;
      end else if (w_hs) begin
         r_rsp    <= '{sum: w_sum, cout: w_cout,
                       id: w_gnt_id, tag: w_sel.tag};
         r_rr_ptr <= ~w_gnt_id;
      end
   end

   assign rsp_sum  = r_rsp.sum;
   assign rsp_cout = r_rsp.cout;
   assign rsp_id   = r_rsp.id;
   assign rsp_tag  = r_rsp.tag;

`ifdef EXP_ADD_ARB_PERF_EN
   logic [15:0] r_perf_g0;
   logic [15:0] r_perf_g1;
   logic [15:0] r_perf_st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_g0 <= '0;
         r_perf_g1 <= '0;
         r_perf_st <= '0;
      end else begin
         if (w_hs_vec[0] && r_perf_g0 != 16'hFFFF)
            r_perf_g0 <= r_perf_g0 + 16'd1;
         if (w_hs_vec[1] && r_perf_g1 != 16'hFFFF)
            r_perf_g1 <= r_perf_g1 + 16'd1;
         if (|req_valid && !w_hs && r_perf_st != 16'hFFFF)
            r_perf_st <= r_perf_st + 16'd1;
      end
   end

   assign perf_grant0 = r_perf_g0;
   assign perf_grant1 = r_perf_g1;
   assign perf_stall  = r_perf_st;
`endif

endmodule

// File: tb/tb_exp_add_arbiter.sv
// Directed self-checking bench for exp_add_arbiter.
// Perf-counter checks run only with EXP_ADD_ARB_PERF_EN defined.
module tb_exp_add_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_sub, req1_sub;
   logic [3:0] req0_tag, req1_tag;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_sum;
   logic       rsp_cout, rsp_id;
   logic [3:0] rsp_tag;
`ifdef EXP_ADD_ARB_PERF_EN
   logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

   int n_vec = 0;
   int n_err = 0;

   exp_add_arbiter #(.W(8), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req0_a    (req0_a),
      .req0_b    (req0_b),
      .req0_sub  (req0_sub),
      .req0_tag  (req0_tag),
      .req1_a    (req1_a),
      .req1_b    (req1_b),
      .req1_sub  (req1_sub),
      .req1_tag  (req1_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag)
`ifdef EXP_ADD_ARB_PERF_EN
     ,.perf_grant0 (perf_grant0),
      .perf_grant1 (perf_grant1),
      .perf_stall  (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time expired, want $finish");
      $fatal(1, "timeout");
   end

   task automatic check_rsp(input string nm, input logic v,
                            input logic [7:0] s, input logic c,
                            input logic id, input logic [3:0] t);
      n_vec++;
      if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_tag} !==
          {v, s, c, id, t}) begin
         n_err++;
         $display("FAIL %s: got v=%b s=%h c=%b id=%b t=%h want v=%b s=%h c=%b id=%b t=%h",
                  nm, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_tag,
                  v, s, c, id, t);
      end
   endtask

   task automatic check_rdy(input string nm, input logic [1:0] exp);
      n_vec++;
      if (req_ready !== exp) begin
         n_err++;
         $display("FAIL %s: req_ready got %b want %b", nm, req_ready, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = 2'b00; rsp_ready = 1'b1;
      req0_a = 0; req0_b = 0; req0_sub = 0; req0_tag = 0;
      req1_a = 0; req1_b = 0; req1_sub = 0; req1_tag = 0;
      rst_n = 1'b0;
      #13;
      check_rsp("reset_state", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
      check_rdy("reset_ready", 2'b00);
      do_reset();
      #1;
      check_rsp("post_release", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_req0_alone();
      req0_a = 8'h7F; req0_b = 8'h01; req0_sub = 1'b0; req0_tag = 4'h3;
      req_valid = 2'b01; rsp_ready = 1'b1;
      #1;
      check_rdy("r0_ready", 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      check_rsp("r0_add", 1'b1, 8'h80, 1'b0, 1'b0, 4'h3);
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL r0_drain: rsp_valid got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_req1_sub();
      req1_a = 8'h05; req1_b = 8'h07; req1_sub = 1'b1; req1_tag = 4'h5;
      req_valid = 2'b10;
      #1;
      check_rdy("r1_ready", 2'b10);
      @(posedge clk); #1;
      req1_a = 8'h07; req1_b = 8'h05; req1_tag = 4'h6;
      check_rsp("r1_borrow", 1'b1, 8'hFE, 1'b0, 1'b1, 4'h5);
      @(posedge clk); #1;
      req_valid = 2'b00;
      check_rsp("r1_noborrow", 1'b1, 8'h02, 1'b1, 1'b1, 4'h6);
      @(posedge clk); #1;
   endtask

   int n0, n1;

   task automatic set_ops();
      req0_a = 8'h10 + 8'(n0); req0_b = 8'h01; req0_sub = 1'b0;
      req0_tag = 4'(n0);
      req1_a = 8'h20; req1_b = 8'(n1 + 1); req1_sub = 1'b1;
      req1_tag = 4'(8 + n1);
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      n0 = 0; n1 = 0;
      set_ops();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         #1;
         check_rdy("alt_grant", (i % 2 == 0) ? 2'b01 : 2'b10);
         @(posedge clk); #1;
         if (i % 2 == 0) begin
            check_rsp("alt_rsp0", 1'b1, 8'h11 + 8'(n0), 1'b0, 1'b0,
                      4'(n0));
            n0++;
         end else begin
            check_rsp("alt_rsp1", 1'b1, 8'h1F - 8'(n1), 1'b1, 1'b1,
                      4'(8 + n1));
            n1++;
         end
         set_ops();
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_rdy("bp_ready", 2'b00);
         @(posedge clk); #1;
         check_rsp("bp_hold", 1'b1, 8'h1D, 1'b1, 1'b1, 4'hA);
      end
      rsp_ready = 1'b1;
      #1;
      check_rdy("bp_release", 2'b01);
      @(posedge clk); #1;
      check_rsp("bp_rsp", 1'b1, 8'h14, 1'b0, 1'b0, 4'h3);
`ifdef EXP_ADD_ARB_PERF_EN
      n_vec++;
      if (perf_stall !== 16'd3) begin
         n_err++;
         $display("FAIL perf_stall: got %0d want 3", perf_stall);
      end
`endif
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_rsp("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check_rdy("mid_first", 2'b01);
      @(posedge clk); #1;
      check_rsp("mid_rsp", 1'b1, 8'h14, 1'b0, 1'b0, 4'h3);
   endtask

`ifdef EXP_ADD_ARB_PERF_EN
   task automatic test_perf_sat();
      do_reset();
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      n_vec++;
      if (perf_grant0 !== 16'hFFFF) begin
         n_err++;
         $display("FAIL perf_grant0: got %h want ffff", perf_grant0);
      end
      n_vec++;
      if (perf_grant1 !== 16'h0000) begin
         n_err++;
         $display("FAIL perf_grant1: got %h want 0000", perf_grant1);
      end
      req_valid = 2'b00;
   endtask
`endif

   initial begin
      test_reset();
      test_req0_alone();
      test_req1_sub();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef EXP_ADD_ARB_PERF_EN
      test_perf_sat();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
